// File: rtl/orv64_cache_noc_arb_pkg.sv
// Shared types for the ORV64 cache-to-NOC request arbiter.
// Holds the CPU/cache request and response payloads, the transaction-id
// layout (source id + local tag), and the arbitration mode encodings.
package orv64_cache_noc_arb_pkg;

    localparam int CPUNOC_TID_SRCID_SIZE = 3;
    localparam int CPUNOC_TID_TID_SIZE   = 4;
    localparam int OUTST_CNT_W           = 4;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    typedef struct packed {
        logic [CPUNOC_TID_SRCID_SIZE-1:0] src;
        logic [CPUNOC_TID_TID_SIZE-1:0]   tid;
    } cpu_noc_tid_t;

    typedef enum logic [1:0] {
        REQ_LD    = 2'd0,
        REQ_ST    = 2'd1,
        REQ_AMO   = 2'd2,
        REQ_FLUSH = 2'd3
    } cpu_cache_if_req_type_t;

    typedef struct packed {
        cpu_noc_tid_t           req_tid;
        cpu_cache_if_req_type_t req_type;
        logic [39:0]            req_paddr;
        logic [63:0]            req_data;
        logic [7:0]             req_mask;
    } cpu_cache_if_req_t;

    typedef struct packed {
        cpu_noc_tid_t resp_tid;
        logic [63:0]  resp_data;
    } cpu_cache_if_resp_t;

endpackage

// File: rtl/orv64_cache_noc_arb_if.sv
// Bundle of all handshake/payload signals around orv64_cache_noc_arb.
//   cpu_if_*   : N_REQ requester-side request/response channels
//   cache_if_* : single NOC-side request/response channel
//   outst_cnt, bad_src_err : debug/status outputs of the arbiter
// Modport slave is the arbiter's view, master is the environment's view.
interface orv64_cache_noc_arb_if
    import orv64_cache_noc_arb_pkg::*;
#(
    parameter int N_REQ = 5
);
    logic [N_REQ-1:0]                    cpu_if_req_valid;
    logic [N_REQ-1:0]                    cpu_if_req_ready;
    cpu_cache_if_req_t [N_REQ-1:0]       cpu_if_req;
    logic [N_REQ-1:0]                    cpu_if_resp_valid;
    logic [N_REQ-1:0]                    cpu_if_resp_ready;
    cpu_cache_if_resp_t [N_REQ-1:0]      cpu_if_resp;

    logic                                cache_if_req_valid;
    logic                                cache_if_req_ready;
    cpu_cache_if_req_t                   cache_if_req;
    logic                                cache_if_resp_valid;
    logic                                cache_if_resp_ready;
    cpu_cache_if_resp_t                  cache_if_resp;

    logic [N_REQ-1:0][OUTST_CNT_W-1:0]   outst_cnt;
    logic                                bad_src_err;

    modport slave (
        input  cpu_if_req_valid, cpu_if_req, cpu_if_resp_ready,
        output cpu_if_req_ready, cpu_if_resp_valid, cpu_if_resp,
        output cache_if_req_valid, cache_if_req, cache_if_resp_ready,
        input  cache_if_req_ready, cache_if_resp_valid, cache_if_resp,
        output outst_cnt, bad_src_err
    );

    modport master (
        output cpu_if_req_valid, cpu_if_req, cpu_if_resp_ready,
        input  cpu_if_req_ready, cpu_if_resp_valid, cpu_if_resp,
        input  cache_if_req_valid, cache_if_req, cache_if_resp_ready,
        output cache_if_req_ready, cache_if_resp_valid, cache_if_resp,
        input  outst_cnt, bad_src_err
    );

endinterface

// File: rtl/orv64_noc_arb.sv
// N-way arbiter: picks one requester out of eligible_i and returns it as a
// one-hot grant_o. MODE 0 is round-robin (the search starts at a pointer that
// moves to grant+1 whenever advance_i is asserted with a grant), MODE 1 is
// fixed priority with index 0 highest.
// Ports: clk, rstn, eligible_i[N], advance_i, grant_o[N].
module orv64_noc_arb #(
    parameter int N    = 5,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] eligible_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  base;
    logic [2*N-1:0] elig2, gnt2;
    logic [N-1:0]   rot, rot_gnt;
    logic           found;

    // Rotate the eligible vector so the highest-priority requester sits at
    // bit 0, pick the lowest set bit, then rotate the grant back.
    always_comb begin
        base    = (MODE == 0) ? ptr_q : '0;
        elig2   = {eligible_i, eligible_i} >> base;
        rot     = elig2[N-1:0];
        rot_gnt = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                rot_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt2    = {rot_gnt, rot_gnt} << base;
        grant_o = gnt2[2*N-1:N];
    end

    always_comb begin
        ptr_d = ptr_q;
        if (MODE == 0 && advance_i) begin
            for (int i = 0; i < N; i++) begin
                if (grant_o[i]) begin
                    ptr_d = (i == N - 1) ? '0 : IW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/orv64_cache_noc_arb.sv
// Arbitrates N_REQ CPU-side cache request ports onto one NOC request port and
// routes NOC responses back to the requester named in resp_tid.src.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : orv64_cache_noc_arb_if.slave, all handshakes and debug outputs
// Request path : one-entry output register, refilled in the same cycle it
//                drains. Each requester may have MAX_OUTST requests in flight.
// Response path: one-entry skid buffer; responses for unknown sources or for
//                requesters with no credit in use are dropped and flagged.
//
// Handshake rule on every channel: a beat transfers on a rising edge where
// valid and ready are both high; once raised, valid and payload hold until
// that transfer. cpu_if_req_ready is a function of the current valids (it is
// the arbiter's grant), so requesters must not wait for ready to raise valid.
module orv64_cache_noc_arb
    import orv64_cache_noc_arb_pkg::*;
#(
    parameter int N_REQ     = 5,
    parameter int MAX_OUTST = 2,
    parameter int ARB_MODE  = 0
) (
    input logic                   clk,
    input logic                   rstn,
    orv64_cache_noc_arb_if.slave  bus
);
    localparam int SRC_W = CPUNOC_TID_SRCID_SIZE;

    if (N_REQ < 2 || N_REQ > 16 || N_REQ > (1 << SRC_W)) begin : g_bad_n_req
        $error("orv64_cache_noc_arb: N_REQ out of range for tid source field");
    end
    if (MAX_OUTST < 1 || MAX_OUTST > 15) begin : g_bad_max_outst
        $error("orv64_cache_noc_arb: MAX_OUTST must be 1..15");
    end

    // ---------------- request path ----------------
    logic [N_REQ-1:0]  eligible, grant;
    logic              req_accept_en, req_fire;
    logic              req_valid_q, req_valid_d;
    cpu_cache_if_req_t req_q, req_d, req_sel;

    logic [N_REQ-1:0][OUTST_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = bus.cpu_if_req_valid[i] && (cnt_q[i] < OUTST_CNT_W'(MAX_OUTST));
        end
    end

    orv64_noc_arb #(
        .N    (N_REQ),
        .MODE (ARB_MODE)
    ) u_arb (
        .clk        (clk),
        .rstn       (rstn),
        .eligible_i (eligible),
        .advance_i  (req_fire),
        .grant_o    (grant)
    );

    // The output register can take a new request when empty or when its
    // current entry leaves this cycle, giving back-to-back throughput.
    assign req_accept_en        = !req_valid_q || bus.cache_if_req_ready;
    assign req_fire             = req_accept_en && (|grant);
    assign bus.cpu_if_req_ready = req_accept_en ? grant : '0;

    // Forwarded payload carries the port index as its source id so the
    // response can be routed back.
    always_comb begin
        req_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                req_sel             = bus.cpu_if_req[i];
                req_sel.req_tid.src = SRC_W'(i);
            end
        end
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_d       = req_q;
        if (req_fire) begin
            req_valid_d = 1'b1;
            req_d       = req_sel;
        end else if (bus.cache_if_req_ready) begin
            req_valid_d = 1'b0;
        end
    end

    assign bus.cache_if_req_valid = req_valid_q;
    assign bus.cache_if_req       = req_q;

    // ---------------- response path ----------------
    logic                     resp_valid_q, resp_valid_d;
    cpu_cache_if_resp_t       resp_q, resp_d;
    logic [N_REQ-1:0]         buf_hit;
    logic                     buf_handoff, resp_fire, in_good;
    logic                     bad_q, bad_d;
    logic [SRC_W-1:0]         in_src;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            buf_hit[i] = resp_valid_q && (resp_q.resp_tid.src == SRC_W'(i));
        end
    end

    assign buf_handoff             = |(buf_hit & bus.cpu_if_resp_ready);
    assign bus.cache_if_resp_ready = !resp_valid_q || buf_handoff;
    assign resp_fire               = bus.cache_if_resp_valid && bus.cache_if_resp_ready;
    assign in_src                  = bus.cache_if_resp.resp_tid.src;

    // A response is legal only if its source still has a credit in use that
    // is not already claimed by the response sitting in the buffer.
    always_comb begin
        in_good = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (in_src == SRC_W'(i)) begin
                in_good = buf_hit[i] ? (cnt_q[i] > OUTST_CNT_W'(1))
                                     : (cnt_q[i] != '0);
            end
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;
        bad_d        = bad_q;
        if (buf_handoff) begin
            resp_valid_d = 1'b0;
        end
        if (resp_fire) begin
            if (in_good) begin
                resp_valid_d = 1'b1;
                resp_d       = bus.cache_if_resp;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_comb begin
        bus.cpu_if_resp_valid = buf_hit;
        for (int i = 0; i < N_REQ; i++) begin
            bus.cpu_if_resp[i] = resp_q;
        end
    end

    // ---------------- outstanding counters ----------------
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            case ({req_fire && grant[i], buf_hit[i] && bus.cpu_if_resp_ready[i]})
                2'b10:   if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + OUTST_CNT_W'(1);
                2'b01:   if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - OUTST_CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    assign bus.outst_cnt   = cnt_q;
    assign bus.bad_src_err = bad_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_valid_q  <= 1'b0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            cnt_q        <= '0;
            bad_q        <= 1'b0;
        end else begin
            req_valid_q  <= req_valid_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            cnt_q        <= cnt_d;
            bad_q        <= bad_d;
        end
    end

endmodule
